// File: rtl/rob_pkg.sv
// Shared types for the multi-writeback reorder buffer: entry kinds, entry layout
// and the default index width.
package rob_pkg;

  localparam int ROB_ADDR_W = 4;

  typedef enum logic [2:0] {
    TOREG  = 3'd0,
    LOAD   = 3'd1,
    STORE  = 3'd2,
    BRANCH = 3'd3,
    JALR   = 3'd4,
    EXIT   = 3'd5
  } rob_type_e;

  typedef struct packed {
    rob_type_e   typ;
    logic [4:0]  rd;
    logic [31:0] value;
    logic [31:0] pc;
    logic [31:0] target;
    logic        pred_taken;
  } rob_entry_t;

  function automatic logic writes_rd(input rob_type_e t);
    return (t == TOREG) || (t == LOAD) || (t == JALR);
  endfunction

endpackage

// File: rtl/rob_wb_merge.sv
// Matches NQ query ids against all writeback ports and picks one winning port
// per query; LOW_WINS selects whether the lowest or highest port index wins.
module rob_wb_merge #(
  parameter int ADDR_W   = 4,
  parameter int WB_PORTS = 3,
  parameter int NQ       = 1,
  parameter bit LOW_WINS = 1'b0
) (
  input  logic [WB_PORTS-1:0]        wb_valid,
  input  logic [WB_PORTS*ADDR_W-1:0] wb_id,
  input  logic [WB_PORTS*32-1:0]     wb_value,
  input  logic [NQ*ADDR_W-1:0]       q_id,
  output logic [NQ-1:0]              q_hit,
  output logic [NQ*32-1:0]           q_value
);

  // Later matches overwrite earlier ones, so scan toward the winning end.
  function automatic int scan_port(input int i);
    return LOW_WINS ? (WB_PORTS - 1 - i) : i;
  endfunction

  always_comb begin
    q_hit   = '0;
    q_value = '0;
    for (int q = 0; q < NQ; q++) begin
      for (int i = 0; i < WB_PORTS; i++) begin
        if (wb_valid[scan_port(i)] &&
            (wb_id[scan_port(i)*ADDR_W +: ADDR_W] == q_id[q*ADDR_W +: ADDR_W])) begin
          q_hit[q]            = 1'b1;
          q_value[q*32 +: 32] = wb_value[scan_port(i)*32 +: 32];
        end
      end
    end
  end

endmodule

// File: rtl/rob_multi_wb.sv
// Reorder buffer with in-order issue, WB_PORTS out-of-order writebacks, single
// in-order commit, commit-time branch/jalr redirects and bypassed operand lookup.
module rob_multi_wb
  import rob_pkg::*;
#(
  parameter int ADDR_W   = ROB_ADDR_W,
  parameter int DEPTH    = 2**ADDR_W,
  parameter int WB_PORTS = 3
) (
  input  logic                       clk_in,
  input  logic                       rst_n_in,
  input  logic                       rdy_in,
  input  logic                       iss_valid,
  output logic                       iss_ready,
  input  logic [2:0]                 iss_type,
  input  logic [4:0]                 iss_rd,
  input  logic                       iss_done,
  input  logic [31:0]                iss_value,
  input  logic [31:0]                iss_pc,
  input  logic [31:0]                iss_target,
  input  logic                       iss_pred_taken,
  output logic [ADDR_W-1:0]          iss_id,
  input  logic [2*ADDR_W-1:0]        q_id,
  output logic [1:0]                 q_ready,
  output logic [63:0]                q_value,
  input  logic [WB_PORTS-1:0]        wb_valid,
  input  logic [WB_PORTS*ADDR_W-1:0] wb_id,
  input  logic [WB_PORTS*32-1:0]     wb_value,
  output logic                       cm_valid,
  output logic [ADDR_W-1:0]          cm_id,
  output logic                       cm_rd_we,
  output logic [4:0]                 cm_rd,
  output logic [31:0]                cm_value,
  output logic [ADDR_W-1:0]          head_id,
  output logic                       head_mem,
  output logic                       flush,
  output logic [31:0]                flush_pc,
  output logic                       bp_valid,
  output logic [31:0]                bp_pc,
  output logic                       bp_taken,
  output logic                       halt
);

  logic [ADDR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [DEPTH-1:0]  busy_q, busy_d, done_q, done_d;
  rob_entry_t        ent_q [DEPTH];
  rob_entry_t        ent_d [DEPTH];
  logic              flush_q, flush_d, bp_valid_q, bp_valid_d;
  logic              bp_taken_q, bp_taken_d, halt_q, halt_d;
  logic [31:0]       flush_pc_q, flush_pc_d, bp_pc_q, bp_pc_d;

  logic                    empty, full, do_issue, do_commit, head_taken;
  rob_entry_t              head_ent;
  logic [DEPTH*ADDR_W-1:0] wbm_qid;
  logic [DEPTH-1:0]        wbm_hit;
  logic [DEPTH*32-1:0]     wbm_value;

  assign empty      = (count_q == '0);
  assign full       = (count_q == (ADDR_W+1)'(DEPTH));
  assign head_ent   = ent_q[head_q];
  assign head_taken = (head_ent.value != 32'd0);

  assign iss_ready = !full && !flush_q;
  assign do_issue  = rdy_in && iss_valid && iss_ready;
  assign iss_id    = tail_q;

  // Commit looks only at registered done; halt blocks everything after EXIT.
  assign do_commit = rdy_in && !empty && done_q[head_q] && !flush_q && !halt_q;
  assign cm_valid  = do_commit;
  assign cm_id     = head_q;
  assign cm_rd     = head_ent.rd;
  assign cm_value  = head_ent.value;
  assign cm_rd_we  = do_commit && writes_rd(head_ent.typ) && (head_ent.rd != 5'd0);

  assign head_id  = head_q;
  assign head_mem = !empty && ((head_ent.typ == LOAD) || (head_ent.typ == STORE));

  assign flush    = flush_q;
  assign flush_pc = flush_pc_q;
  assign bp_valid = bp_valid_q;
  assign bp_pc    = bp_pc_q;
  assign bp_taken = bp_taken_q;
  assign halt     = halt_q;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wb_qid
      assign wbm_qid[gi*ADDR_W +: ADDR_W] = ADDR_W'(gi);
    end
  endgenerate

  rob_wb_merge #(
    .ADDR_W   (ADDR_W),
    .WB_PORTS (WB_PORTS),
    .NQ       (DEPTH),
    .LOW_WINS (1'b0)
  ) u_wb_merge (
    .wb_valid (wb_valid),
    .wb_id    (wb_id),
    .wb_value (wb_value),
    .q_id     (wbm_qid),
    .q_hit    (wbm_hit),
    .q_value  (wbm_value)
  );

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_lookup
      logic [ADDR_W-1:0] lk_id;
      logic              lk_hit;
      logic [31:0]       lk_bypass;

      assign lk_id = q_id[gi*ADDR_W +: ADDR_W];

      rob_wb_merge #(
        .ADDR_W   (ADDR_W),
        .WB_PORTS (WB_PORTS),
        .NQ       (1),
        .LOW_WINS (1'b1)
      ) u_bypass (
        .wb_valid (wb_valid),
        .wb_id    (wb_id),
        .wb_value (wb_value),
        .q_id     (lk_id),
        .q_hit    (lk_hit),
        .q_value  (lk_bypass)
      );

      assign q_ready[gi]          = done_q[lk_id] || lk_hit;
      assign q_value[gi*32 +: 32] = done_q[lk_id] ? ent_q[lk_id].value :
                                    (lk_hit ? lk_bypass : 32'd0);
    end
  endgenerate

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    busy_d     = busy_q;
    done_d     = done_q;
    ent_d      = ent_q;
    flush_d    = flush_q;
    flush_pc_d = flush_pc_q;
    bp_valid_d = bp_valid_q;
    bp_pc_d    = bp_pc_q;
    bp_taken_d = bp_taken_q;
    halt_d     = halt_q;

    if (rdy_in) begin
      flush_d    = 1'b0;
      bp_valid_d = 1'b0;
      if (flush_q) begin
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
        busy_d  = '0;
        done_d  = '0;
      end else begin
        for (int e = 0; e < DEPTH; e++) begin
          if (wbm_hit[e] && busy_q[e]) begin
            done_d[e] = 1'b1;
            if (ent_q[e].typ == JALR) ent_d[e].target = wbm_value[e*32 +: 32];
            else                      ent_d[e].value  = wbm_value[e*32 +: 32];
          end
        end

        if (do_issue) begin
          busy_d[tail_q] = 1'b1;
          done_d[tail_q] = iss_done;
          ent_d[tail_q]  = '{typ: rob_type_e'(iss_type), rd: iss_rd, value: iss_value,
                             pc: iss_pc, target: iss_target, pred_taken: iss_pred_taken};
          tail_d         = tail_q + ADDR_W'(1);
        end

        if (do_commit) begin
          busy_d[head_q] = 1'b0;
          done_d[head_q] = 1'b0;
          head_d         = head_q + ADDR_W'(1);
          case (head_ent.typ)
            BRANCH: begin
              bp_valid_d = 1'b1;
              bp_pc_d    = head_ent.pc;
              bp_taken_d = head_taken;
              if (head_taken != head_ent.pred_taken) begin
                flush_d    = 1'b1;
                flush_pc_d = head_taken ? head_ent.target : head_ent.pc + 32'd4;
              end
            end
            JALR: begin
              flush_d    = 1'b1;
              flush_pc_d = head_ent.target & 32'hFFFF_FFFE;
            end
            EXIT:    halt_d = 1'b1;
            default: ;
          endcase
        end

        count_d = count_q + (ADDR_W+1)'(do_issue) - (ADDR_W+1)'(do_commit);
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      busy_q     <= '0;
      done_q     <= '0;
      flush_q    <= 1'b0;
      flush_pc_q <= '0;
      bp_valid_q <= 1'b0;
      bp_pc_q    <= '0;
      bp_taken_q <= 1'b0;
      halt_q     <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      flush_q    <= flush_d;
      flush_pc_q <= flush_pc_d;
      bp_valid_q <= bp_valid_d;
      bp_pc_q    <= bp_pc_d;
      bp_taken_q <= bp_taken_d;
      halt_q     <= halt_d;
    end
  end

  // Payload is only meaningful while busy, so it needs no reset.
  always_ff @(posedge clk_in) begin
    ent_q <= ent_d;
  end

endmodule

// File: tb/tb_rob_multi_wb.sv
// Directed bench for rob_multi_wb: fill/wrap loop, a vector table for out-of-order
// writeback and redirects, and hand sequences for bypass, stall, halt and reset.
module tb_rob_multi_wb;
  import rob_pkg::*;

  logic        clk_in, rst_n_in, rdy_in;
  logic        iss_valid, iss_ready, iss_done, iss_pred_taken;
  logic [2:0]  iss_type;
  logic [4:0]  iss_rd;
  logic [31:0] iss_value, iss_pc, iss_target;
  logic [3:0]  iss_id;
  logic [7:0]  q_id;
  logic [1:0]  q_ready;
  logic [63:0] q_value;
  logic [2:0]  wb_valid;
  logic [11:0] wb_id;
  logic [95:0] wb_value;
  logic        cm_valid, cm_rd_we, head_mem, flush, bp_valid, bp_taken, halt;
  logic [3:0]  cm_id, head_id;
  logic [4:0]  cm_rd;
  logic [31:0] cm_value, flush_pc, bp_pc;

  int n_tests = 0;
  int n_fail  = 0;

  rob_multi_wb #(.ADDR_W(4), .DEPTH(16), .WB_PORTS(3)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_type(iss_type), .iss_rd(iss_rd),
    .iss_done(iss_done), .iss_value(iss_value), .iss_pc(iss_pc), .iss_target(iss_target),
    .iss_pred_taken(iss_pred_taken), .iss_id(iss_id),
    .q_id(q_id), .q_ready(q_ready), .q_value(q_value),
    .wb_valid(wb_valid), .wb_id(wb_id), .wb_value(wb_value),
    .cm_valid(cm_valid), .cm_id(cm_id), .cm_rd_we(cm_rd_we), .cm_rd(cm_rd), .cm_value(cm_value),
    .head_id(head_id), .head_mem(head_mem),
    .flush(flush), .flush_pc(flush_pc), .bp_valid(bp_valid), .bp_pc(bp_pc),
    .bp_taken(bp_taken), .halt(halt)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Two ports writing the same id in one cycle is illegal stimulus.
  always @(negedge clk_in) begin
    if (rst_n_in) begin
      for (int a = 0; a < 3; a++)
        for (int b = a + 1; b < 3; b++)
          assert (!(wb_valid[a] && wb_valid[b] && (wb_id[a*4 +: 4] == wb_id[b*4 +: 4])))
            else $error("illegal duplicate writeback id on ports %0d and %0d", a, b);
    end
  end

  typedef struct {
    logic iv; logic [2:0] ityp; logic [4:0] ird; logic idone;
    logic [31:0] ival, ipc, itgt; logic ipred;
    logic [2:0] wbv; logic [11:0] wbid; logic [95:0] wbval;
    logic e_rdy; logic [3:0] e_id; logic e_cv; logic [3:0] e_cid;
    logic [31:0] e_cval; logic e_cwe;
    logic e_fl; logic [31:0] e_fpc; logic e_bpv; logic e_bpt; logic [31:0] e_bpc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic iv, input logic [2:0] ityp, input logic [4:0] ird, input logic idone,
    input logic [31:0] ival, input logic [31:0] ipc, input logic [31:0] itgt, input logic ipred,
    input logic [2:0] wbv, input logic [11:0] wbid, input logic [95:0] wbval,
    input logic e_rdy, input logic [3:0] e_id, input logic e_cv, input logic [3:0] e_cid,
    input logic [31:0] e_cval, input logic e_cwe,
    input logic e_fl, input logic [31:0] e_fpc, input logic e_bpv, input logic e_bpt,
    input logic [31:0] e_bpc);
    vec_t v;
    v.iv = iv; v.ityp = ityp; v.ird = ird; v.idone = idone;
    v.ival = ival; v.ipc = ipc; v.itgt = itgt; v.ipred = ipred;
    v.wbv = wbv; v.wbid = wbid; v.wbval = wbval;
    v.e_rdy = e_rdy; v.e_id = e_id; v.e_cv = e_cv; v.e_cid = e_cid;
    v.e_cval = e_cval; v.e_cwe = e_cwe;
    v.e_fl = e_fl; v.e_fpc = e_fpc; v.e_bpv = e_bpv; v.e_bpt = e_bpt; v.e_bpc = e_bpc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    rdy_in = 1'b1; iss_valid = 1'b0; iss_type = 3'd0; iss_rd = 5'd0; iss_done = 1'b0;
    iss_value = '0; iss_pc = '0; iss_target = '0; iss_pred_taken = 1'b0;
    q_id = '0; wb_valid = '0; wb_id = '0; wb_value = '0;
  endtask

  task automatic issue(input logic [2:0] t, input logic [4:0] rd, input logic dn,
                       input logic [31:0] val, input logic [31:0] pc);
    iss_valid = 1'b1; iss_type = t; iss_rd = rd; iss_done = dn; iss_value = val; iss_pc = pc;
  endtask

  task automatic do_reset();
    rst_n_in = 1'b0;
    idle();
    repeat (2) @(posedge clk_in);
    #1 rst_n_in = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n_in = 1'b0;
    idle();
    #2;
    chk("reset iss_ready", iss_ready, 1);
    chk("reset iss_id", iss_id, 0);
    chk("reset cm_valid", cm_valid, 0);
    chk("reset flush", flush, 0);
    chk("reset bp_valid", bp_valid, 0);
    chk("reset halt", halt, 0);
    chk("reset q_ready", q_ready, 0);
    do_reset();

    // Fill: entry 0 is left not-done so nothing commits until all 16 are in.
    for (int i = 0; i < 16; i++) begin
      issue(TOREG, 5'(i + 1), (i != 0), 32'(i), 32'h0);
      @(negedge clk_in);
      chk($sformatf("fill%0d iss_id", i), iss_id, 64'(i));
      chk($sformatf("fill%0d iss_ready", i), iss_ready, 1);
      chk($sformatf("fill%0d cm_valid", i), cm_valid, 0);
      tick();
    end
    issue(TOREG, 5'd7, 1'b1, 32'h77, 32'h0);
    wb_valid = 3'b001; wb_id = 12'h000; wb_value = {64'h0, 32'h100};
    @(negedge clk_in);
    chk("full iss_ready", iss_ready, 0);
    chk("full cm_valid", cm_valid, 0);
    tick();
    wb_valid = '0;
    @(negedge clk_in);
    chk("full+commit cm_valid", cm_valid, 1);
    chk("full+commit cm_value", cm_value, 32'h100);
    chk("full+commit iss_ready", iss_ready, 0);
    tick();
    @(negedge clk_in);
    chk("wrap iss_ready", iss_ready, 1);
    chk("wrap iss_id", iss_id, 0);
    chk("wrap cm_id", cm_id, 1);
    tick();
    iss_valid = 1'b0;
    for (int j = 2; j < 16; j++) begin
      @(negedge clk_in);
      chk($sformatf("drain%0d cm_valid", j), cm_valid, 1);
      chk($sformatf("drain%0d cm_id", j), cm_id, 64'(j));
      chk($sformatf("drain%0d cm_value", j), cm_value, 64'(j));
      chk($sformatf("drain%0d cm_rd_we", j), cm_rd_we, 1);
      $display("[TB] drain commit id=%0d value=0x%0h", cm_id, cm_value);
      tick();
    end
    @(negedge clk_in);
    chk("wrapped cm_id", cm_id, 0);
    chk("wrapped cm_value", cm_value, 32'h77);
    chk("wrapped cm_rd", cm_rd, 7);
    tick();
    @(negedge clk_in);
    chk("drained cm_valid", cm_valid, 0);

    // iv typ rd done value pc target pred | wbv wbid wbval |
    // rdy id cv cid cval cwe | fl fpc bpv bpt bpc
    vecs.push_back(mk(1, TOREG, 3, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, TOREG, 4, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, TOREG, 5, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, TOREG, 0, 0, 0, 0, 0, 0, 3'b101, {4'd2, 4'd0, 4'd0},
                      {32'h22, 32'h0, 32'h11}, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, TOREG, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 1, 0, 32'h11, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, TOREG, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, TOREG, 0, 0, 0, 0, 0, 0, 3'b010, {4'd0, 4'd1, 4'd0},
                      {32'h0, 32'h33, 32'h0}, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, TOREG, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 1, 1, 32'h33, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, TOREG, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 1, 2, 32'h22, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, TOREG, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, BRANCH, 0, 0, 0, 32'h100, 32'h180, 0, 0, 0, 0,
                      1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, TOREG, 0, 0, 0, 0, 0, 0, 3'b001, {4'd0, 4'd0, 4'd3},
                      {32'h0, 32'h0, 32'h1}, 1, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, TOREG, 9, 1, 32'h55, 0, 0, 0, 0, 0, 0, 1, 4, 1, 3, 32'h1, 0,
                      0, 0, 0, 0, 0));
    vecs.push_back(mk(1, TOREG, 9, 1, 32'h99, 0, 0, 0, 0, 0, 0, 0, 5, 0, 0, 0, 0,
                      1, 32'h180, 1, 1, 32'h100));
    vecs.push_back(mk(1, JALR, 1, 0, 32'h204, 32'h200, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0,
                      0, 32'h180, 0, 1, 32'h100));
    vecs.push_back(mk(1, TOREG, 2, 1, 32'h66, 0, 0, 0, 3'b100, {4'd0, 4'd0, 4'd0},
                      {32'h205, 32'h0, 32'h0}, 1, 1, 0, 0, 0, 0, 0, 32'h180, 0, 1, 32'h100));
    vecs.push_back(mk(0, TOREG, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 1, 0, 32'h204, 1,
                      0, 32'h180, 0, 1, 32'h100));
    vecs.push_back(mk(0, TOREG, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0,
                      1, 32'h204, 0, 1, 32'h100));
    vecs.push_back(mk(0, TOREG, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0,
                      0, 32'h204, 0, 1, 32'h100));

    do_reset();
    foreach (vecs[r]) begin
      iss_valid = vecs[r].iv; iss_type = vecs[r].ityp; iss_rd = vecs[r].ird;
      iss_done = vecs[r].idone; iss_value = vecs[r].ival; iss_pc = vecs[r].ipc;
      iss_target = vecs[r].itgt; iss_pred_taken = vecs[r].ipred;
      wb_valid = vecs[r].wbv; wb_id = vecs[r].wbid; wb_value = vecs[r].wbval;
      @(negedge clk_in);
      chk($sformatf("vec%0d iss_ready", r), iss_ready, vecs[r].e_rdy);
      chk($sformatf("vec%0d iss_id", r), iss_id, vecs[r].e_id);
      chk($sformatf("vec%0d cm_valid", r), cm_valid, vecs[r].e_cv);
      if (vecs[r].e_cv) begin
        chk($sformatf("vec%0d cm_id", r), cm_id, vecs[r].e_cid);
        chk($sformatf("vec%0d cm_value", r), cm_value, vecs[r].e_cval);
        chk($sformatf("vec%0d cm_rd_we", r), cm_rd_we, vecs[r].e_cwe);
      end
      chk($sformatf("vec%0d flush", r), flush, vecs[r].e_fl);
      chk($sformatf("vec%0d flush_pc", r), flush_pc, vecs[r].e_fpc);
      chk($sformatf("vec%0d bp_valid", r), bp_valid, vecs[r].e_bpv);
      chk($sformatf("vec%0d bp_taken", r), bp_taken, vecs[r].e_bpt);
      chk($sformatf("vec%0d bp_pc", r), bp_pc, vecs[r].e_bpc);
      $display("[TB] vec %0d iss_id=%0d cm_valid=%0b cm_id=%0d flush=%0b flush_pc=0x%0h",
               r, iss_id, cm_valid, cm_id, flush, flush_pc);
      tick();
    end
    idle();

    // Bypass: ids 0..3 outstanding, lookups on ids 3 and 2.
    for (int i = 0; i < 4; i++) begin
      issue(TOREG, 5'd1, 1'b0, 32'h0, 32'h0);
      tick();
    end
    iss_valid = 1'b0;
    q_id = {4'd2, 4'd3};
    wb_valid = 3'b010; wb_id = {4'd0, 4'd3, 4'd0}; wb_value = {32'h0, 32'hABCD, 32'h0};
    @(negedge clk_in);
    chk("bypass q_ready", q_ready, 2'b01);
    chk("bypass q_value0", q_value[31:0], 32'hABCD);
    chk("bypass q_value1", q_value[63:32], 32'h0);
    $display("[TB] bypass q_ready=%b q_value=0x%0h", q_ready, q_value);
    tick();
    wb_valid = '0;
    @(negedge clk_in);
    chk("stored q_ready", q_ready, 2'b01);
    chk("stored q_value0", q_value[31:0], 32'hABCD);
    tick();
    wb_valid = 3'b101; wb_id = {4'd2, 4'd0, 4'd3}; wb_value = {32'h77, 32'h0, 32'h1234};
    @(negedge clk_in);
    chk("stored-first q_value0", q_value[31:0], 32'hABCD);
    chk("port2 q_ready", q_ready, 2'b11);
    chk("port2 q_value1", q_value[63:32], 32'h77);
    tick();

    // Stall with a pending jalr flush.
    do_reset();
    issue(JALR, 5'd0, 1'b0, 32'h0, 32'h2F0);
    tick();
    iss_valid = 1'b0;
    wb_valid = 3'b001; wb_id = 12'h000; wb_value = {64'h0, 32'h301};
    tick();
    wb_valid = '0;
    @(negedge clk_in);
    chk("stall jalr cm_valid", cm_valid, 1);
    chk("stall jalr rd0 cm_rd_we", cm_rd_we, 0);
    tick();
    rdy_in = 1'b0;
    @(negedge clk_in);
    chk("stall flush", flush, 1);
    chk("stall flush_pc", flush_pc, 32'h300);
    repeat (3) tick();
    @(negedge clk_in);
    chk("stall flush held", flush, 1);
    chk("stall iss_ready", iss_ready, 0);
    chk("stall cm_valid", cm_valid, 0);
    rdy_in = 1'b1;
    tick();
    @(negedge clk_in);
    chk("post-flush flush", flush, 0);
    chk("post-flush iss_ready", iss_ready, 1);
    chk("post-flush iss_id", iss_id, 0);
    $display("[TB] stall released flush=%0b iss_id=%0d", flush, iss_id);

    // head_mem, then EXIT halting later commits.
    tick();
    issue(STORE, 5'd0, 1'b0, 32'h0, 32'h0);
    tick();
    iss_valid = 1'b0;
    @(negedge clk_in);
    chk("head_mem store", head_mem, 1);
    tick();
    wb_valid = 3'b001; wb_id = 12'h000; wb_value = '0;
    tick();
    wb_valid = '0;
    @(negedge clk_in);
    chk("store cm_valid", cm_valid, 1);
    chk("store cm_rd_we", cm_rd_we, 0);
    issue(EXIT, 5'd0, 1'b1, 32'h0, 32'h0);
    tick();
    issue(TOREG, 5'd5, 1'b1, 32'h5, 32'h0);
    @(negedge clk_in);
    chk("exit cm_valid", cm_valid, 1);
    chk("exit cm_id", cm_id, 1);
    tick();
    iss_valid = 1'b0;
    @(negedge clk_in);
    chk("halt set", halt, 1);
    chk("halted cm_valid", cm_valid, 0);
    tick();
    @(negedge clk_in);
    chk("halt held", halt, 1);
    chk("halted cm_valid 2", cm_valid, 0);
    $display("[TB] halt=%0b head_id=%0d", halt, head_id);

    // Asynchronous reset mid-cycle while stalled.
    rdy_in = 1'b0;
    #2 rst_n_in = 1'b0;
    #1;
    chk("async rst halt", halt, 0);
    chk("async rst iss_id", iss_id, 0);
    chk("async rst head_id", head_id, 0);
    chk("async rst cm_valid", cm_valid, 0);
    chk("async rst flush_pc", flush_pc, 0);
    chk("async rst iss_ready", iss_ready, 1);
    rst_n_in = 1'b1;
    rdy_in = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
